// File: rtl/primitive_pkg.sv
// Shared types and helpers for the screen-space primitive FIFO.
// Default geometry is a 2D triangle with 10-bit screen coordinates.
package primitive_pkg;

    localparam int VERTS_TRI = 3;
    localparam int COORDS_2D = 2;
    localparam int CW_SCREEN = 10;

    typedef logic [COORDS_2D-1:0][CW_SCREEN-1:0] vertex_t;
    typedef vertex_t [VERTS_TRI-1:0]              triangle_t;

    // Number of address bits needed to index n entries (at least one bit).
    function automatic int clog2_depth(input int unsigned n);
        int r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/primitive_fifo_ram.sv
// Simple dual-port storage for primitive_fifo: one write port, one
// registered read port. The read register holds its value when re=0,
// so the FIFO can leave a prefetched word parked in it.
module primitive_fifo_ram
    import primitive_pkg::*;
#(
    parameter int DEPTH = 100,
    parameter int W     = 60,
    localparam int AW   = clog2_depth(DEPTH)
) (
    input  logic          Clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_r [DEPTH];
    logic [W-1:0] rdata_r;

    // Write port and registered read port; storage carries no reset.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/primitive_fifo.sv
// First-word-fall-through FIFO for screen-space primitives.
// Data path: RAM -> q stage (RAM read register, or a bypass register) -> out
// register. A word written into an empty FIFO goes through the RAM and shows
// up two edges later. A word written behind live entries may skip the RAM
// (into q, or straight into out when it replaces the last entry) so that it
// is already presented when it reaches the head, giving bubble-free reads.
module primitive_fifo
    import primitive_pkg::*;
#(
    parameter int VERTS     = VERTS_TRI,
    parameter int COORDS    = COORDS_2D,
    parameter int CW        = CW_SCREEN,
    parameter int DEPTH     = 100,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic                               flush,
    input  logic                               w_en,
    input  logic [VERTS-1:0][COORDS-1:0][CW-1:0] triangle_in,
    input  logic                               r_en,
    output logic [VERTS-1:0][COORDS-1:0][CW-1:0] triangle_out,
    output logic                               out_valid,
    output logic                               is_empty,
    output logic                               is_full,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]         level,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int W  = VERTS * COORDS * CW;
    localparam int AW = clog2_depth(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
    localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL    = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_LVL    = LW'(AE_THRESH);

    // Advance a RAM pointer with an explicit wrap at the last entry.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end else begin
            return p + AW'(1);
        end
    endfunction

    // Control state
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [LW-1:0] level_r, ram_cnt_r;
    logic          out_valid_r, q_valid_r, q_byp_r;
    logic          overflow_r, underflow_r;

    // Data path registers (not reset)
    logic [W-1:0]  out_data_r, byp_data_r;

    // Next-state and decode signals
    logic [AW-1:0] wr_ptr_s, rd_ptr_s;
    logic [LW-1:0] level_s, ram_cnt_s;
    logic          out_valid_s, q_valid_s, q_byp_s;
    logic          overflow_s, underflow_s;
    logic [W-1:0]  out_data_s, byp_data_s, q_data_s, ram_rdata_s, wdata_s;
    logic          full_s, w_acc_s, r_acc_s, q_take_s, q_free_s, ram_empty_s;
    logic          out_byp_s, q_load_byp_s, ram_we_s, ram_re_s;

    assign wdata_s = triangle_in;

    // Access decisions: acceptance, stage movement and RAM port controls.
    always_comb begin
        full_s       = (level_r == DEPTH_LVL);
        w_acc_s      = w_en && !full_s && !flush;
        r_acc_s      = r_en && out_valid_r && !flush;
        ram_empty_s  = (ram_cnt_r == LW'(0));
        q_take_s     = q_valid_r && (!out_valid_r || r_acc_s);
        q_free_s     = !q_valid_r || q_take_s;
        // Last entry popped while its successor arrives: hand it to out directly.
        out_byp_s    = w_acc_s && r_acc_s && !q_valid_r && ram_empty_s;
        // Word behind a live entry with nothing queued in RAM: park it in q.
        q_load_byp_s = w_acc_s && !out_byp_s && ram_empty_s && q_free_s
                       && (out_valid_r || q_valid_r);
        ram_we_s     = w_acc_s && !out_byp_s && !q_load_byp_s;
        ram_re_s     = !flush && !ram_empty_s && q_free_s;
        q_data_s     = q_byp_r ? byp_data_r : ram_rdata_s;
    end

    // Next values for pointers, counters, stage flags and sticky errors.
    always_comb begin
        wr_ptr_s    = wr_ptr_r;
        rd_ptr_s    = rd_ptr_r;
        level_s     = level_r;
        ram_cnt_s   = ram_cnt_r;
        q_valid_s   = q_valid_r;
        q_byp_s     = q_byp_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        byp_data_s  = byp_data_r;
        overflow_s  = overflow_r;
        underflow_s = underflow_r;

        if (ram_we_s) begin
            wr_ptr_s = next_ptr(wr_ptr_r);
        end else begin
            wr_ptr_s = wr_ptr_r;
        end

        if (ram_re_s) begin
            rd_ptr_s = next_ptr(rd_ptr_r);
        end else begin
            rd_ptr_s = rd_ptr_r;
        end

        case ({w_acc_s, r_acc_s})
            2'b10:   level_s = level_r + LW'(1);
            2'b01:   level_s = level_r - LW'(1);
            default: level_s = level_r;
        endcase

        case ({ram_we_s, ram_re_s})
            2'b10:   ram_cnt_s = ram_cnt_r + LW'(1);
            2'b01:   ram_cnt_s = ram_cnt_r - LW'(1);
            default: ram_cnt_s = ram_cnt_r;
        endcase

        q_valid_s = ram_re_s || q_load_byp_s || (q_valid_r && !q_take_s);

        if (ram_re_s) begin
            q_byp_s = 1'b0;
        end else if (q_load_byp_s) begin
            q_byp_s = 1'b1;
        end else begin
            q_byp_s = q_byp_r;
        end

        if (q_load_byp_s) begin
            byp_data_s = wdata_s;
        end else begin
            byp_data_s = byp_data_r;
        end

        if (q_take_s) begin
            out_valid_s = 1'b1;
            out_data_s  = q_data_s;
        end else if (out_byp_s) begin
            out_valid_s = 1'b1;
            out_data_s  = wdata_s;
        end else if (r_acc_s) begin
            out_valid_s = 1'b0;
        end else begin
            out_valid_s = out_valid_r;
        end

        overflow_s  = overflow_r  || (w_en && full_s && !flush);
        underflow_s = underflow_r || (r_en && !out_valid_r && !flush);
    end

    // Control state register; Reset clears everything, flush keeps the sticky flags.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            ram_cnt_r   <= '0;
            q_valid_r   <= 1'b0;
            q_byp_r     <= 1'b0;
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            ram_cnt_r   <= '0;
            q_valid_r   <= 1'b0;
            q_byp_r     <= 1'b0;
            out_valid_r <= 1'b0;
            overflow_r  <= overflow_r;
            underflow_r <= underflow_r;
        end else begin
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            level_r     <= level_s;
            ram_cnt_r   <= ram_cnt_s;
            q_valid_r   <= q_valid_s;
            q_byp_r     <= q_byp_s;
            out_valid_r <= out_valid_s;
            overflow_r  <= overflow_s;
            underflow_r <= underflow_s;
        end
    end

    // Data path registers; contents only matter while the matching valid is set.
    always_ff @(posedge Clk) begin
        out_data_r <= out_data_s;
        byp_data_r <= byp_data_s;
    end

    primitive_fifo_ram #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_ram (
        .Clk   (Clk),
        .we    (ram_we_s && !Reset),
        .waddr (wr_ptr_r),
        .wdata (wdata_s),
        .re    (ram_re_s && !Reset),
        .raddr (rd_ptr_r),
        .rdata (ram_rdata_s)
    );

    assign triangle_out = out_data_r;
    assign out_valid    = out_valid_r;
    assign level        = level_r;
    assign is_empty     = (level_r == LW'(0));
    assign is_full      = (level_r == DEPTH_LVL);
    assign almost_full  = (level_r >= AF_LVL);
    assign almost_empty = (level_r <= AE_LVL);
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_primitive_fifo.sv
// Bench for primitive_fifo: directed scenarios plus random traffic, checked
// every cycle against a queue model. Each queued word carries the edge from
// which it may be shown at the head: two edges after a write into an empty
// FIFO, otherwise as soon as it becomes the head.
module tb_primitive_fifo;

    localparam int VERTS  = 3;
    localparam int COORDS = 2;
    localparam int CW     = 10;
    localparam int DEPTH  = 4;
    localparam int AF     = 3;
    localparam int AE     = 1;
    localparam int W      = VERTS * COORDS * CW;
    localparam int LW     = $clog2(DEPTH + 1);

    logic                                Clk = 1'b0;
    logic                                Reset, flush, w_en, r_en;
    logic [VERTS-1:0][COORDS-1:0][CW-1:0] triangle_in, triangle_out;
    logic                                out_valid, is_empty, is_full;
    logic                                almost_full, almost_empty;
    logic [LW-1:0]                       level;
    logic                                overflow, underflow;

    primitive_fifo #(
        .VERTS     (VERTS),
        .COORDS    (COORDS),
        .CW        (CW),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .flush        (flush),
        .w_en         (w_en),
        .triangle_in  (triangle_in),
        .r_en         (r_en),
        .triangle_out (triangle_out),
        .out_valid    (out_valid),
        .is_empty     (is_empty),
        .is_full      (is_full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [W-1:0] data;
        int           vis;
    } ent_t;

    ent_t         mq[$];
    int           cyc = 0;
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;
    int           checks_cnt = 0;
    int           errors_cnt = 0;
    logic [W-1:0] tri_tab [5];

    // Single comparison point: counts and reports mismatches.
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // Triangle whose coordinates count up from base (vertex 0 x first).
    function automatic logic [W-1:0] mk_tri(input int base);
        logic [W-1:0] t;
        t = '0;
        for (int k = 0; k < VERTS * COORDS; k++) begin
            t[k*CW +: CW] = CW'(base + k);
        end
        return t;
    endfunction

    // One clock: drive inputs, advance the model at the edge, check after it.
    task automatic step(input logic w, input logic r, input logic fl, input logic rst,
                        input logic [W-1:0] d);
        int   sz;
        bit   full, vis, exp_vis;
        ent_t e;
        w_en        = w;
        r_en        = r;
        flush       = fl;
        Reset       = rst;
        triangle_in = d;
        sz   = mq.size();
        full = (sz == DEPTH);
        vis  = (sz > 0) && (mq[0].vis <= cyc);
        @(posedge Clk);
        cyc++;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (w && full) m_ovf = 1'b1;
            if (r && !vis) m_unf = 1'b1;
            if (r && vis) void'(mq.pop_front());
            if (w && !full) begin
                e.data = d;
                e.vis  = (sz == 0) ? cyc + 2 : cyc;
                mq.push_back(e);
            end
        end
        #1;
        exp_vis = (mq.size() > 0) && (mq[0].vis <= cyc);
        check_eq("level", 64'(level), 64'(mq.size()));
        check_eq("out_valid", 64'(out_valid), 64'(exp_vis));
        if (exp_vis) check_eq("triangle_out", 64'(triangle_out), 64'(mq[0].data));
        check_eq("is_empty", 64'(is_empty), 64'(mq.size() == 0));
        check_eq("is_full", 64'(is_full), 64'(mq.size() == DEPTH));
        check_eq("almost_full", 64'(almost_full), 64'(mq.size() >= AF));
        check_eq("almost_empty", 64'(almost_empty), 64'(mq.size() <= AE));
        check_eq("overflow", 64'(overflow), 64'(m_ovf));
        check_eq("underflow", 64'(underflow), 64'(m_unf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [W-1:0] rd;
        bit           rw, rr, rf, rx;
        for (int i = 0; i < 5; i++) tri_tab[i] = mk_tri(6 * i + 1);

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);

        // Single write: level=1 at once, visible two edges later, then pop
        step(1'b1, 1'b0, 1'b0, 1'b0, tri_tab[0]);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        idle(1);

        // Fill, overflow on a fifth write, drain back-to-back
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, tri_tab[i]);
        step(1'b1, 1'b0, 1'b0, 1'b0, tri_tab[4]);
        idle(1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        idle(2);

        // Simultaneous read/write at full, then at empty
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, tri_tab[i]);
        idle(1);
        step(1'b1, 1'b1, 1'b0, 1'b0, tri_tab[4]);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        idle(1);
        step(1'b1, 1'b1, 1'b0, 1'b0, tri_tab[2]);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);

        // Streaming at level 2 for 10 cycles
        step(1'b1, 1'b0, 1'b0, 1'b0, tri_tab[0]);
        step(1'b1, 1'b0, 1'b0, 1'b0, tri_tab[1]);
        idle(2);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, mk_tri(100 + 7 * i));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);

        // Flush at level 3 together with a write, then refill
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, tri_tab[i]);
        idle(2);
        step(1'b1, 1'b0, 1'b1, 1'b0, tri_tab[4]);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 1'b0, tri_tab[3]);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);

        // Reset one edge after a write into an empty FIFO
        step(1'b1, 1'b0, 1'b0, 1'b0, tri_tab[1]);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        idle(3);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 800; i++) begin
            rw = ($urandom_range(0, 99) < 55);
            rr = ($urandom_range(0, 99) < 50);
            rf = ($urandom_range(0, 99) < 2);
            rx = ($urandom_range(0, 199) < 1);
            rd = W'({$urandom, $urandom});
            step(rw, rr, rf, rx, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/primitive_fifo.md
Name: primitive_fifo

Overview:
Parametrised first-word-fall-through (FWFT) FIFO for screen-space primitives between the vertex/projection stage and the rasteriser. Vertex count, coordinate count and coordinate width are generic, so triangles, lines and points use the same block. Adds a level count, almost-full/almost-empty thresholds, flush, correct simultaneous read/write at the full and empty boundaries, and sticky overflow/underflow flags. Storage is inferred on-chip RAM (simple dual-port, registered read), fronted by a small prefetch stage.

Parameters:
VERTS, 3, vertices per primitive
COORDS, 2, coordinates per vertex (x,y; 3 adds z)
CW, 10, bits per coordinate
DEPTH, 100, number of entries; any value >= 2, not restricted to a power of two
AF_THRESH, DEPTH-2, almost_full asserts when level >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH

Ports:
Clk  in  1  clock
Reset  in  1  synchronous, active-high reset
flush  in  1  synchronous clear of contents
w_en  in  1  write request
triangle_in  in  [VERTS-1:0][COORDS-1:0][CW-1:0]  write data
r_en  in  1  pop request for the word on triangle_out
triangle_out  out  [VERTS-1:0][COORDS-1:0][CW-1:0]  head-of-queue data, valid while out_valid=1
out_valid  out  1  triangle_out holds the oldest entry
is_empty  out  1  level==0
is_full  out  1  level==DEPTH
almost_full  out  1  level>=AF_THRESH
almost_empty  out  1  level<=AE_THRESH
level  out  $clog2(DEPTH+1)  entries held, including the prefetch stage
overflow  out  1  sticky: w_en while is_full
underflow  out  1  sticky: r_en while !out_valid

Behaviour:
- Clock is Clk. Reset is synchronous and active-high.
- Reset: pointers=0, level=0, out_valid=0, overflow=0, underflow=0, is_empty=1, is_full=0, almost_empty=1, almost_full=(AF_THRESH==0). triangle_out is don't-care while out_valid=0.
- Write accepted when w_en && !is_full. Otherwise the data is dropped and overflow is set.
- Read accepted when r_en && out_valid. It is gated by out_valid, not !is_empty. r_en with out_valid=0 is ignored and sets underflow.
- Pointer wrap: explicit compare with DEPTH-1 returns to 0. No power-of-two masking.
- level updates on the edge after the access: +1 for a write only, -1 for a read only, unchanged for both or neither. It never leaves 0..DEPTH.
- Simultaneous w_en and r_en:
  - when full: the read is accepted, the write is rejected, overflow is set, level decrements.
  - when empty: the write is accepted, the read is ignored, underflow is set, level increments.
  - otherwise both are accepted and level is unchanged.
- Fall-through latency: a write sampled at edge E into an empty FIFO gives out_valid=1 with that data after edge E+2. level=1 after edge E, while out_valid is still 0.
- Back-to-back reads: when level>1, an accepted read at edge E presents the next entry after edge E with out_valid held at 1, with no bubble. Sustained throughput is 1 read and 1 write per cycle.
- Ordering: strict FIFO. The data-path is not reset, only control state.
- flush, and Reset, take priority over w_en and r_en in the same cycle.
  - flush clears the pointers, level and out_valid. The next cycle shows the empty state.
  - overflow and underflow are cleared only by Reset.
- Status outputs are combinational decodes of the level register, so they are stable for the whole cycle.

Decomposition:
- Package primitive_pkg holds:
  - parameters VERTS_TRI=3, COORDS_2D=2 and CW_SCREEN=10;
  - typedef vertex_t as [COORDS-1:0][CW-1:0];
  - typedef triangle_t as [VERTS-1:0] of vertex_t;
  - the function clog2_depth.
- One sub-module, primitive_fifo_ram: simple dual-port RAM with parameters DEPTH and a width equal to the flattened data width. It has a registered read and no reset. The prefetch/FWFT logic and all counters stay in primitive_fifo.

Test Plan:
- All tests use DEPTH=4, AF_THRESH=3, AE_THRESH=1, CW=10.
- Reset, then write T0=(x=1..6), one write per cycle -> level=1 after the edge, out_valid=1 with triangle_out=T0 two edges after the write; is_empty=0, almost_empty=1.
- Fill with T0..T3, then write T4 -> is_full=1, almost_full=1 at level 3 onward, T4 dropped, overflow=1. Drain with r_en held high -> T0, T1, T2, T3 on consecutive cycles with no bubble, then out_valid=0 and level=0.
- At level=4, pulse w_en and r_en together -> T0 popped, write rejected, level=3, overflow set. At level=0 with both high -> level=1, underflow=1, out_valid=1 two edges later.
- At level=2 with continuous w_en and r_en for 10 cycles (wrap crossing index 3->0) -> level stays 2 and the output order matches the input order exactly.
- At level=3, assert flush together with w_en -> next cycle level=0, out_valid=0, is_empty=1, sticky flags retained. A subsequent write reappears with the 2-cycle latency.
- Write then Reset mid-fall-through (Reset at edge E+1) -> out_valid stays 0, level=0, overflow=0, underflow=0.
